// File: rtl/glorb_alu.sv
// glorb_alu -- registered integer ALU of the glorbcore datapath.
//
// Decodes the R-type fields of the instruction and combines operand A (rd_data)
// with operand B (rs1_data). The DW-bit result and the Z/N/C/V flags are captured
// on every rising clk, so they appear one cycle after the inputs. A new operation
// can start every cycle.
//
// Optional feature macro: SHIFT_OPS_EN
//   defined   : alt=1 with funct 01/10/11 selects SLL/SRL/SRA of A by B[$clog2(DW)-1:0]
//   undefined : alt is ignored for funct 01/10/11 and no shifter is built
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset (clears out and flags)
//   instruction  in   IW  [7:6] rs1 idx, [5:4] rd idx, [3:2] funct, [1] alt, [0] opcode
//   rs1_data     in   DW  operand B
//   rd_data      in   DW  operand A
//   out          out  DW  registered result
//   flag_z/n/c/v out  1   registered zero / negative / carry(no-borrow) / overflow
module glorb_alu #(
  parameter int DW = 8,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_c,
  output logic          flag_v
);

  logic [1:0]    w_funct;
  logic          w_alt;
  logic          w_opcode;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_res;
  logic          w_c;
  logic          w_v;
  logic          w_unused;

  logic [DW-1:0] r_out;
  logic          r_z, r_n, r_c, r_v;

  assign w_funct  = instruction[3:2];
  assign w_alt    = instruction[1];
  assign w_opcode = instruction[0];
  // Register indices and upper instruction bits are decoded elsewhere.
  assign w_unused = ^instruction;

  // Extra MSB of each adder carries out of bit DW-1. Subtract is A + ~B + 1,
  // so its carry-out is 1 exactly when no borrow occurs (A >= B unsigned).
  assign w_sum  = {1'b0, rd_data} + {1'b0, rs1_data};
  assign w_diff = {1'b0, rd_data} + {1'b0, ~rs1_data} + (DW+1)'(1);

`ifdef SHIFT_OPS_EN
  localparam int SHW = $clog2(DW);
  logic [SHW-1:0] w_sh;
  logic [DW:0]    w_sll;
  logic [DW:0]    w_srl;
  logic [DW:0]    w_sra;
  assign w_sh = rs1_data[SHW-1:0];
  // One guard bit beside the operand catches the last bit shifted out;
  // it stays 0 for a zero shift amount.
  assign w_sll = {1'b0, rd_data} << w_sh;
  assign w_srl = {rd_data, 1'b0} >> w_sh;
  assign w_sra = $signed({rd_data, 1'b0}) >>> w_sh;
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_funct)
      2'b00: begin
        if (w_alt) begin
          w_res = w_diff[DW-1:0];
          w_c   = w_diff[DW];
          w_v   = (rd_data[DW-1] != rs1_data[DW-1]) && (w_res[DW-1] != rd_data[DW-1]);
        end else begin
          w_res = w_sum[DW-1:0];
          w_c   = w_sum[DW];
          w_v   = (rd_data[DW-1] == rs1_data[DW-1]) && (w_res[DW-1] != rd_data[DW-1]);
        end
      end
      2'b01: begin
        w_res = rd_data & rs1_data;
`ifdef SHIFT_OPS_EN
        if (w_alt) begin
          w_res = w_sll[DW-1:0];
          w_c   = w_sll[DW];
        end
`endif
      end
      2'b10: begin
        w_res = rd_data | rs1_data;
`ifdef SHIFT_OPS_EN
        if (w_alt) begin
          w_res = w_srl[DW:1];
          w_c   = w_srl[0];
        end
`endif
      end
      default: begin
        w_res = rd_data ^ rs1_data;
`ifdef SHIFT_OPS_EN
        if (w_alt) begin
          w_res = w_sra[DW:1];
          w_c   = w_sra[0];
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
    end else if (w_opcode) begin
      // Non-ALU instruction: forward rd_data, keep the previous flags.
      r_out <= rd_data;
    end else begin
      r_out <= w_res;
      r_z   <= (w_res == '0);
      r_n   <= w_res[DW-1];
      r_c   <= w_c;
      r_v   <= w_v;
    end
  end

  assign out    = r_out;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule

// File: tb/tb_glorb_alu.sv
module tb_glorb_alu;
  localparam int DW = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instruction;
  logic [DW-1:0] rs1_data, rd_data;
  logic [DW-1:0] out;
  logic          flag_z, flag_n, flag_c, flag_v;

  int checks   = 0;
  int failures = 0;

  // reference state: last result and flags
  int m_out;
  int m_z, m_n, m_c, m_v;

  glorb_alu #(.DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .rs1_data(rs1_data), .rd_data(rd_data), .out(out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {out, flag_z, flag_n, flag_c, flag_v};
  endfunction

  function automatic logic [11:0] mexp();
    return {m_out[7:0], m_z[0], m_n[0], m_c[0], m_v[0]};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Plain-integer reference: results are computed as mathematical values and
  // reduced modulo 256; flags come from value-range tests.
  task automatic model(input int instr, input int a, input int b);
    int sa, sb, r, sr, fn, sh;
    bit alt;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    fn  = (instr >> 2) & 3;
    alt = instr[1];
    sh  = b % 8;
    if (instr[0]) begin
      m_out = a;
      return;
    end
    m_c = 0; m_v = 0;
    if (fn == 0 && !alt) begin
      r = a + b; sr = sa + sb;
      m_c = (r > 255); m_v = (sr > 127 || sr < -128);
    end else if (fn == 0) begin
      r = a - b; sr = sa - sb;
      m_c = (a >= b); m_v = (sr > 127 || sr < -128);
`ifdef SHIFT_OPS_EN
    end else if (alt && fn == 1) begin
      r = a * (2 ** sh);
      m_c = (sh == 0) ? 0 : (a / (2 ** (8 - sh))) % 2;
    end else if (alt && fn == 2) begin
      r = a / (2 ** sh);
      m_c = (sh == 0) ? 0 : (a / (2 ** (sh - 1))) % 2;
    end else if (alt && fn == 3) begin
      r = sa >>> sh;
      m_c = (sh == 0) ? 0 : ((sa >>> (sh - 1)) & 1);
`endif
    end else if (fn == 1) r = a & b;
    else if (fn == 2) r = a | b;
    else r = a ^ b;
    m_out = ((r % 256) + 256) % 256;
    m_z = (m_out == 0);
    m_n = (m_out >= 128);
  endtask

  task automatic step(input string tag, input int instr, input int a, input int b);
    instruction = instr[7:0];
    rd_data     = a[7:0];
    rs1_data    = b[7:0];
    model(instr, a, b);
    @(posedge clk); #1;
    check(tag, obs(), mexp());
  endtask

  // directed step: checked against the reference and a hand-computed constant
  task automatic dstep(input string tag, input int instr, input int a, input int b,
                       input logic [11:0] exp);
    step(tag, instr, a, b);
    check({tag, "_const"}, obs(), exp);
  endtask

  initial begin
    rst = 1'b1; instruction = '0; rd_data = '0; rs1_data = '0;
    m_out = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    #2;
    check("reset_state", obs(), 12'h000);
    #1 rst = 1'b0;

    dstep("add_wrap",  8'h40, 8'h01, 8'hFF, {8'h00, 4'b1010});
    dstep("add_ff_ff", 8'h40, 8'hFF, 8'hFF, {8'hFE, 4'b0110});
    dstep("add_plain", 8'h40, 8'h22, 8'h11, {8'h33, 4'b0000});
    dstep("add_ovf",   8'h40, 8'h7F, 8'h01, {8'h80, 4'b0101});
    dstep("sub_neg",   8'h42, 8'h05, 8'h07, {8'hFE, 4'b0100});
    dstep("sub_wrap",  8'h42, 8'h00, 8'h01, {8'hFF, 4'b0100});
    dstep("sub_ovf",   8'h42, 8'h80, 8'h01, {8'h7F, 4'b0011});
    dstep("and_aa",    8'h44, 8'hAA, 8'hFF, {8'hAA, 4'b0100});
    dstep("and_89",    8'h44, 8'h89, 8'hA8, {8'h88, 4'b0100});
    dstep("and_zero",  8'h44, 8'hFF, 8'h00, {8'h00, 4'b1000});
    dstep("pass_hold", 8'h41, 8'h5A, 8'h33, {8'h5A, 4'b1000});
    dstep("or_89",     8'h48, 8'h89, 8'hA8, {8'hA9, 4'b0100});
    dstep("or_ff",     8'h48, 8'hAA, 8'hFF, {8'hFF, 4'b0100});
    dstep("xor_89",    8'h4C, 8'h89, 8'hA8, {8'h21, 4'b0000});
`ifdef SHIFT_OPS_EN
    dstep("sll_81",    8'h46, 8'h81, 8'h01, {8'h02, 4'b0010});
    dstep("sra_80",    8'h4E, 8'h80, 8'h03, {8'hF0, 4'b0100});
`else
    dstep("alt_and",   8'h46, 8'h81, 8'h01, {8'h01, 4'b0000});
    dstep("alt_xor",   8'h4E, 8'h80, 8'h03, {8'h83, 4'b0100});
`endif

    // reset between edges, with an ADD in flight
    dstep("pre_rst",   8'h40, 8'hFF, 8'hFF, {8'hFE, 4'b0110});
    instruction = 8'h40; rd_data = 8'h7F; rs1_data = 8'h01;
    #2 rst = 1'b1;
    #1 check("rst_async", obs(), 12'h000);
    @(posedge clk); #1;
    check("rst_held", obs(), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    m_out = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    dstep("post_rst",  8'h40, 8'h22, 8'h11, {8'h33, 4'b0000});
    dstep("post_pass", 8'h01, 8'hC3, 8'h00, {8'hC3, 4'b0000});

    for (int i = 0; i < 300; i++) begin
      step("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
